// File: rtl/regfile_pkg.sv
// Shared constants and types for the KgpRisc general-purpose register bank.
//
// Contents:
//   DATA_W, ADDR_W, NUM_REGS  geometry of the register bank
//   WR_COUNT_W                width of the committed-write counter
//   reg_addr_t, reg_data_t    register index and register word types
//   sat_inc()                 saturating increment used by the write counter
package regfile_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned ADDR_W     = 5;
  localparam int unsigned NUM_REGS   = 2 ** ADDR_W;
  localparam int unsigned WR_COUNT_W = 16;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  // Holds at all-ones instead of wrapping back to zero.
  function automatic logic [WR_COUNT_W-1:0] sat_inc(input logic [WR_COUNT_W-1:0] val);
    logic [WR_COUNT_W-1:0] res;
    res = (&val) ? val : val + 1'b1;
    return res;
  endfunction

endpackage

// File: rtl/reg_read_port.sv
// One combinational read port of the register bank.
//
// A 32-to-1 word multiplexer selects the addressed register. After the mux,
// three overrides apply in increasing priority:
//   zero register   reads of index 0 return 0 when ZERO_REG is set
//   bypass          when BYPASS is set, a same-cycle write to the addressed
//                   (non-zero) register is forwarded from i_wr_data
//   reset           the port reads 0 while i_rst is high
//
// Parameters:
//   ZERO_REG  1: register 0 reads as zero; 0: ordinary register
//   BYPASS    1: forward the in-flight write; 0: stored state only
//
// Ports:
//   i_rst      asynchronous active-high reset (forces output to 0)
//   i_regs     flattened register array, entry i at i_regs[i]
//   i_rd_addr  register index to read
//   i_wr_en    write enable of the write port (bypass only)
//   i_wr_addr  write destination index (bypass only)
//   i_wr_data  write data (bypass only)
//   o_rd_data  selected register word
module reg_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned ZERO_REG = 1,
  parameter bit          BYPASS   = 1'b0
) (
  input  logic                               i_rst,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]    i_regs,
  input  reg_addr_t                          i_rd_addr,
  input  logic                               i_wr_en,
  input  reg_addr_t                          i_wr_addr,
  input  reg_data_t                          i_wr_data,
  output reg_data_t                          o_rd_data
);

  reg_data_t w_mux_word;
  logic      w_is_zero_reg;
  logic      w_fwd_hit;

  assign w_mux_word    = i_regs[i_rd_addr];
  assign w_is_zero_reg = (ZERO_REG != 0) && (i_rd_addr == '0);
  assign w_fwd_hit     = BYPASS && i_wr_en && (i_wr_addr == i_rd_addr) && !w_is_zero_reg;

  always_comb begin
    o_rd_data = w_mux_word;
    if (w_is_zero_reg) begin
      o_rd_data = '0;
    end
    if (w_fwd_hit) begin
      o_rd_data = i_wr_data;
    end
    // The in-flight write data is not yet cleared by reset, so gate it here.
    if (i_rst) begin
      o_rd_data = '0;
    end
  end

endmodule

// File: rtl/reg_bank_32x32.sv
// 32-entry x 32-bit general-purpose register bank for the KgpRisc datapath.
//
// One write port (writeback stage), two operand read ports (rs, rt) and one
// debug read port. Reads are combinational and return the state as of the
// last clock edge. wr_count counts committed writes since reset and
// saturates at 0xFFFF.
//
// Configuration:
//   ZERO_REG           parameter; 1 hardwires register 0 to zero
//   REGFILE_BYPASS_EN  macro; when defined, rs/rt forward a same-cycle write
//                      to the addressed register (dbg never forwards)
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   wr_en     write enable
//   wr_addr   destination register index
//   wr_data   value to write
//   rs_addr   read port A index
//   rt_addr   read port B index
//   dbg_addr  debug read index
//   rs_data   read port A data
//   rt_data   read port B data
//   dbg_data  debug read data
//   wr_count  committed writes since reset, saturating
module reg_bank_32x32
  import regfile_pkg::*;
#(
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  reg_addr_t             wr_addr,
  input  reg_data_t             wr_data,
  input  reg_addr_t             rs_addr,
  input  reg_addr_t             rt_addr,
  input  reg_addr_t             dbg_addr,
  output reg_data_t             rs_data,
  output reg_data_t             rt_data,
  output reg_data_t             dbg_data,
  output logic [WR_COUNT_W-1:0] wr_count
);

`ifdef REGFILE_BYPASS_EN
  localparam bit OperandBypass = 1'b1;
`else
  localparam bit OperandBypass = 1'b0;
`endif

  logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;
  logic [WR_COUNT_W-1:0]           r_wr_count;
  logic                            w_wr_commit;
  logic [NUM_REGS-1:0]             w_wr_sel;

  // Writes to a hardwired zero register are dropped and not counted.
  assign w_wr_commit = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  // One-hot write decoder.
  always_comb begin
    w_wr_sel = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      w_wr_sel[i] = w_wr_commit && (wr_addr == ADDR_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_regs[g] <= '0;
      end else if (w_wr_sel[g]) begin
        r_regs[g] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_count <= '0;
    end else if (w_wr_commit) begin
      r_wr_count <= sat_inc(r_wr_count);
    end
  end

  assign wr_count = r_wr_count;

  reg_read_port #(
    .ZERO_REG (ZERO_REG),
    .BYPASS   (OperandBypass)
  ) u_rs_port (
    .i_rst     (rst),
    .i_regs    (r_regs),
    .i_rd_addr (rs_addr),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .o_rd_data (rs_data)
  );

  reg_read_port #(
    .ZERO_REG (ZERO_REG),
    .BYPASS   (OperandBypass)
  ) u_rt_port (
    .i_rst     (rst),
    .i_regs    (r_regs),
    .i_rd_addr (rt_addr),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .o_rd_data (rt_data)
  );

  // The debug port always shows stored state.
  reg_read_port #(
    .ZERO_REG (ZERO_REG),
    .BYPASS   (1'b0)
  ) u_dbg_port (
    .i_rst     (rst),
    .i_regs    (r_regs),
    .i_rd_addr (dbg_addr),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .o_rd_data (dbg_data)
  );

endmodule

// File: tb/tb_reg_bank_32x32.sv
// Self-checking bench for reg_bank_32x32. Two instances share all inputs:
// u_dut_z (ZERO_REG=1) and u_dut_nz (ZERO_REG=0). Expected values come from
// a behavioural model and are queued when stimulus is applied, then popped
// and compared once the outputs have settled.
module tb_reg_bank_32x32;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  dbg_addr;

  logic [31:0] rs_z, rt_z, dbg_z, rs_nz, rt_nz, dbg_nz;
  logic [15:0] cnt_z, cnt_nz;

  reg_bank_32x32 #(.ZERO_REG(1)) u_dut_z (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .dbg_addr (dbg_addr),
    .rs_data  (rs_z),
    .rt_data  (rt_z),
    .dbg_data (dbg_z),
    .wr_count (cnt_z)
  );

  reg_bank_32x32 #(.ZERO_REG(0)) u_dut_nz (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .dbg_addr (dbg_addr),
    .rs_data  (rs_nz),
    .rt_data  (rt_nz),
    .dbg_data (dbg_nz),
    .wr_count (cnt_nz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mem_z / cnt_z_m for ZERO_REG=1, mem_nz / cnt_nz_m for ZERO_REG=0.
  logic [31:0] mem_z [32];
  logic [31:0] mem_nz[32];
  int unsigned cnt_z_m;
  int unsigned cnt_nz_m;

  int n_checks;
  int n_errors;

  typedef struct {
    string       tag;
    int          port;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mem_z[i]  = '0;
      mem_nz[i] = '0;
    end
    cnt_z_m  = 0;
    cnt_nz_m = 0;
  endtask

  // Called right at a rising edge, with the inputs that were presented to it.
  task automatic model_commit();
    if (!rst && wr_en) begin
      mem_nz[wr_addr] = wr_data;
      if (cnt_nz_m < 32'hFFFF) cnt_nz_m++;
      if (wr_addr != 5'd0) begin
        mem_z[wr_addr] = wr_data;
        if (cnt_z_m < 32'hFFFF) cnt_z_m++;
      end
    end
  endtask

  function automatic logic [31:0] exp_rd(input bit zr, input bit fwd_port, input logic [4:0] a);
    logic [31:0] v;
    if (rst) return 32'h0;
    if (zr) v = (a == 5'd0) ? 32'h0 : mem_z[a];
    else    v = mem_nz[a];
`ifdef REGFILE_BYPASS_EN
    if (fwd_port && wr_en && (wr_addr == a) && !(zr && (a == 5'd0))) v = wr_data;
`else
    if (fwd_port && 1'b0) v = wr_data;
`endif
    return v;
  endfunction

  function automatic logic [31:0] observe(input int p);
    logic [31:0] v;
    case (p)
      0:       v = rs_z;
      1:       v = rt_z;
      2:       v = dbg_z;
      3:       v = rs_nz;
      4:       v = rt_nz;
      5:       v = dbg_nz;
      6:       v = {16'h0, cnt_z};
      default: v = {16'h0, cnt_nz};
    endcase
    return v;
  endfunction

  task automatic push(input string tag, input int p, input logic [31:0] v);
    exp_t e;
    e.tag  = tag;
    e.port = p;
    e.val  = v;
    sb_q.push_back(e);
  endtask

  // Queue expectations for the current inputs, let outputs settle, then compare.
  task automatic sample(input string tag);
    exp_t e;
    push({tag, ".rs_z"},   0, exp_rd(1'b1, 1'b1, rs_addr));
    push({tag, ".rt_z"},   1, exp_rd(1'b1, 1'b1, rt_addr));
    push({tag, ".dbg_z"},  2, exp_rd(1'b1, 1'b0, dbg_addr));
    push({tag, ".rs_nz"},  3, exp_rd(1'b0, 1'b1, rs_addr));
    push({tag, ".rt_nz"},  4, exp_rd(1'b0, 1'b1, rt_addr));
    push({tag, ".dbg_nz"}, 5, exp_rd(1'b0, 1'b0, dbg_addr));
    push({tag, ".cnt_z"},  6, cnt_z_m);
    push({tag, ".cnt_nz"}, 7, cnt_nz_m);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, observe(e.port), e.val);
    end
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    model_commit();
    #1 wr_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c,
                    input string tag);
    @(negedge clk);
    rs_addr  = a;
    rt_addr  = b;
    dbg_addr = c;
    sample(tag);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rs_addr  = '0;
    rt_addr  = '0;
    dbg_addr = '0;
    model_reset();
    #2 sample("reset");
    @(negedge clk);
    rst = 1'b0;

    // Basic write/read
    do_write(5'd7, 32'h1234_5678);
    rd(5'd7, 5'd7, 5'd7, "basic");

    // Zero register
    do_write(5'd0, 32'hFFFF_FFFF);
    rd(5'd0, 5'd0, 5'd0, "zero_reg");

    // Same-cycle hazard on reg3
    do_write(5'd3, 32'h0000_000A);
    @(negedge clk);
    wr_en    = 1'b1;
    wr_addr  = 5'd3;
    wr_data  = 32'h0000_000B;
    rs_addr  = 5'd3;
    rt_addr  = 5'd3;
    dbg_addr = 5'd3;
    sample("haz_same");
    @(posedge clk);
    model_commit();
    #1 wr_en = 1'b0;
    sample("haz_next");

    // Asynchronous reset mid-cycle
    do_write(5'd5, 32'hDEAD_BEEF);
    rd(5'd5, 5'd5, 5'd5, "pre_rst");
    @(negedge clk);
    #2 rst = 1'b1;
    model_reset();
    sample("rst_async");
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'(i), 5'(i), $sformatf("rst_rd%0d", i));
    end
    @(negedge clk);
    rst = 1'b0;

    // Full sweep
    for (int i = 0; i < 32; i++) begin
      do_write(5'(i), 32'(i) * 32'h0101_0101);
    end
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), 5'(31 - i), 5'(i), $sformatf("sweep%0d", i));
    end

    // Counter saturation
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = 5'd1;
    wr_data = 32'h0000_0001;
    repeat (65540) begin
      @(posedge clk);
      model_commit();
    end
    #1 wr_en = 1'b0;
    rd(5'd1, 5'd0, 5'd1, "sat");

    // Reset colliding with a write to reg9
    @(negedge clk);
    wr_en    = 1'b1;
    wr_addr  = 5'd9;
    wr_data  = 32'h0000_0055;
    rs_addr  = 5'd9;
    rt_addr  = 5'd9;
    dbg_addr = 5'd9;
    rst      = 1'b1;
    model_reset();
    sample("rst_wr_hold");
    @(posedge clk);
    model_commit();
    @(negedge clk);
    rst   = 1'b0;
    wr_en = 1'b0;
    sample("rst_wr_after");

    // First edge after reset release commits
    do_write(5'd9, 32'h0000_0066);
    rd(5'd9, 5'd9, 5'd9, "post_rst_wr");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
